// File: rtl/key_scan_pkg.sv
// key_scan_pkg: shared states, idle patterns and encoders for the keypad scanner
package key_scan_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;
  localparam logic [3:0] COL_INIT = 4'b1110;
  localparam logic [3:0] ROW_IDLE = 4'b1111;
  function automatic logic [1:0] enc4(input logic [3:0] v);
    return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : 2'd3;
  endfunction
  function automatic logic one_low(input logic [3:0] r);
    logic [3:0] x;
    x = ~r;
    return (x != 4'd0) && ((x & (x - 4'd1)) == 4'd0);
  endfunction
endpackage

// File: rtl/key_tick_gen.sv
// key_tick_gen: free-running counter producing a one-cycle scan tick every CNT_MAX+1 clocks
module key_tick_gen #(
  parameter logic [15:0] CNT_MAX = 16'd49999
) (
  input  logic sys_clk,
  input  logic sys_rst,
  output logic tick
);
  logic [15:0] cnt_1ms;
  assign tick = cnt_1ms == CNT_MAX;
  always_ff @(posedge sys_clk)
    if (sys_rst) cnt_1ms <= 16'd0;
    else cnt_1ms <= tick ? 16'd0 : cnt_1ms + 16'd1;
endmodule

// File: rtl/key_scan_4x4.sv
// key_scan_4x4: 4x4 active-low keypad scanner with debounced press code, valid pulse and held flag
module key_scan_4x4
  import key_scan_pkg::*;
#(
  parameter logic [15:0] CNT_MAX = 16'd49999,
  parameter logic [4:0]  DEB_CNT = 5'd20
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  state_t     state, state_n;
  logic       tick;
  logic [3:0] row_m, row_s, row_lat, row_lat_n, col_n, code_n;
  logic [1:0] col_idx, col_idx_n;
  logic [4:0] deb, deb_n, deb_inc;
  logic       valid_n, held_n;
  logic [3:0] col_rot;
  key_tick_gen #(.CNT_MAX(CNT_MAX)) u_tick (.sys_clk(sys_clk), .sys_rst(sys_rst), .tick(tick));
  assign col_rot = {col_out[2:0], col_out[3]};
  assign deb_inc = (deb == DEB_CNT) ? deb : deb + 5'd1;
  always_comb begin
    state_n   = state;
    row_lat_n = row_lat;
    col_idx_n = col_idx;
    deb_n     = deb;
    col_n     = col_out;
    code_n    = key_code;
    held_n    = key_held;
    valid_n   = 1'b0;
    if (tick)
      case (state)
        SCAN:
          if (one_low(row_s)) begin
            row_lat_n = row_s;
            col_idx_n = enc4(~col_out);
            deb_n     = 5'd1;
            state_n   = DEBOUNCE;
          end else col_n = col_rot;
        DEBOUNCE:
          if (row_s == row_lat) begin
            deb_n = deb_inc;
            if (deb_inc == DEB_CNT) begin
              code_n  = {enc4(~row_lat), col_idx};
              valid_n = 1'b1;
              held_n  = 1'b1;
              state_n = HOLD;
            end
          end else begin
            deb_n   = 5'd0;
            state_n = SCAN;
            col_n   = col_rot;
          end
        HOLD:
          if (row_s == ROW_IDLE) begin
            deb_n   = 5'd1;
            state_n = RELEASE;
          end
        RELEASE:
          if (row_s == ROW_IDLE) begin
            deb_n = deb_inc;
            if (deb_inc == DEB_CNT) begin
              held_n  = 1'b0;
              state_n = SCAN;
              col_n   = col_rot;
            end
          end else begin
            deb_n   = 5'd0;
            state_n = HOLD;
          end
        default: state_n = SCAN;
      endcase
  end
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      state     <= SCAN;
      row_m     <= ROW_IDLE;
      row_s     <= ROW_IDLE;
      row_lat   <= ROW_IDLE;
      col_idx   <= 2'd0;
      deb       <= 5'd0;
      col_out   <= COL_INIT;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_n;
      row_m     <= row_in;
      row_s     <= row_m;
      row_lat   <= row_lat_n;
      col_idx   <= col_idx_n;
      deb       <= deb_n;
      col_out   <= col_n;
      key_code  <= code_n;
      key_valid <= valid_n;
      key_held  <= held_n;
    end
endmodule

// File: tb/tb_key_scan_4x4.sv
// tb_key_scan_4x4: keypad-model bench comparing the scanner against a tick-level behavioural model
module tb_key_scan_4x4;
  localparam logic [15:0] CNT_MAX = 16'd9;
  localparam int          DEB     = 3;
  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [3:0]  row_in, col_out, key_code;
  logic        key_valid, key_held;
  logic [15:0] keys = 16'd0;
  logic        raw = 1'b0;
  logic [3:0]  raw_row = 4'b1111;
  int          n_chk = 0, n_fail = 0, pulses = 0;
  key_scan_4x4 #(.CNT_MAX(CNT_MAX), .DEB_CNT(5'(DEB))) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .row_in(row_in),
    .col_out(col_out), .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );
  always #5 sys_clk = ~sys_clk;
  always_comb begin
    row_in = raw ? raw_row : 4'b1111;
    if (!raw)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (keys[r*4+c] && col_out[c] === 1'b0) row_in[r] = 1'b0;
  end
  function automatic int low_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction
  // model: a pointer to the driven column plus flags for "locked on a key", "held" and "releasing"
  int         m_cnt, m_pos, m_streak;
  bit         m_init = 1'b0, m_locked, m_held, m_rel, m_pulse;
  logic [3:0] m_lat, m_code, m_rm, m_rs, r;
  always @(posedge sys_clk) begin
    if (sys_rst) begin
      m_cnt = 0; m_pos = 0; m_streak = 0; m_locked = 0; m_held = 0; m_rel = 0;
      m_pulse = 0; m_code = 4'd0; m_lat = 4'hF; m_rm = 4'hF; m_rs = 4'hF; m_init = 1'b1;
    end else begin
      m_pulse = 0;
      if (m_cnt == int'(CNT_MAX)) begin
        r = m_rs;
        if (!m_locked) begin
          if ($countones(~r) == 1) begin m_locked = 1; m_lat = r; m_streak = 1; end
          else m_pos = (m_pos + 1) % 4;
        end else if (!m_held) begin
          if (r == m_lat) begin
            m_streak++;
            if (m_streak >= DEB) begin
              m_held = 1; m_pulse = 1; m_code = 4'(low_idx(~m_lat) * 4 + m_pos);
            end
          end else begin m_locked = 0; m_streak = 0; m_pos = (m_pos + 1) % 4; end
        end else if (!m_rel) begin
          if (r == 4'hF) begin m_rel = 1; m_streak = 1; end
        end else if (r == 4'hF) begin
          m_streak++;
          if (m_streak >= DEB) begin m_held = 0; m_rel = 0; m_locked = 0; m_pos = (m_pos + 1) % 4; end
        end else begin m_rel = 0; m_streak = 0; end
      end
      m_cnt = (m_cnt == int'(CNT_MAX)) ? 0 : m_cnt + 1;
      m_rs = m_rm;
      m_rm = row_in;
    end
  end
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask
  always @(negedge sys_clk)
    if (m_init) begin
      chk("col_out", col_out, ~(4'b0001 << m_pos));
      chk("key_valid", {3'b0, key_valid}, {3'b0, m_pulse});
      chk("key_code", key_code, m_code);
      chk("key_held", {3'b0, key_held}, {3'b0, m_held});
      if (key_valid === 1'b1) pulses++;
    end
  task automatic run(input int n);
    repeat (n) @(negedge sys_clk);
    #1;
  endtask
  initial begin
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    #1;
    chk("rst_col", col_out, 4'b1110);
    chk("rst_code", key_code, 4'd0);
    chk("rst_valid", {3'b0, key_valid}, 4'd0);
    chk("rst_held", {3'b0, key_held}, 4'd0);
    run(120);
    chk("idle_col", col_out, 4'b1110);
    chk("idle_pulses", 4'(pulses), 4'd0);
    keys[6] = 1'b1;
    run(49);
    chk("pre_valid", {3'b0, key_valid}, 4'd0);
    run(1);
    chk("press_valid", {3'b0, key_valid}, 4'd1);
    chk("press_code", key_code, 4'd6);
    chk("press_held", {3'b0, key_held}, 4'd1);
    chk("press_col", col_out, 4'b1011);
    run(1);
    chk("post_valid", {3'b0, key_valid}, 4'd0);
    run(9);
    keys[6] = 1'b0;
    run(20);
    chk("rel_mid_held", {3'b0, key_held}, 4'd1);
    run(10);
    chk("rel_held", {3'b0, key_held}, 4'd0);
    chk("rel_col", col_out, 4'b0111);
    chk("rel_pulses", 4'(pulses), 4'd1);
    raw = 1'b1;
    repeat (4) begin
      raw_row = 4'b1110;
      run(10);
      raw_row = 4'b1111;
      run(10);
    end
    chk("bounce_pulses", 4'(pulses), 4'd1);
    chk("bounce_col", col_out, 4'b0111);
    raw_row = 4'b0110;
    run(60);
    chk("ambig_col", col_out, 4'b1101);
    chk("ambig_pulses", 4'(pulses), 4'd1);
    raw_row = 4'b1011;
    run(15);
    sys_rst = 1'b1;
    run(1);
    chk("mrst_col", col_out, 4'b1110);
    chk("mrst_code", key_code, 4'd0);
    chk("mrst_held", {3'b0, key_held}, 4'd0);
    chk("mrst_valid", {3'b0, key_valid}, 4'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    raw = 1'b0;
    raw_row = 4'b1111;
    #1;
    keys[13] = 1'b1;
    run(60);
    chk("k13_code", key_code, 4'd13);
    chk("k13_col", col_out, 4'b1101);
    chk("k13_pulses", 4'(pulses), 4'd2);
    keys[0] = 1'b1;
    run(40);
    chk("second_ignored", 4'(pulses), 4'd2);
    chk("second_held", {3'b0, key_held}, 4'd1);
    keys[13] = 1'b0;
    run(100);
    chk("k0_code", key_code, 4'd0);
    chk("k0_col", col_out, 4'b1110);
    chk("k0_pulses", 4'(pulses), 4'd3);
    keys[0] = 1'b0;
    run(40);
    chk("final_held", {3'b0, key_held}, 4'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
